regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
- Write-side controller for the 32x32 register file (single write port: WE3/A3/WD3, written on the falling clock edge).
- Merges two result sources into that one port: in-order pipeline writeback, and a multi-cycle unit (MDU: multiply/divide) that completes late.
- Buffers MDU results in a small FIFO.
- Keeps a busy scoreboard of destinations with outstanding MDU results, so the hazard unit can stall dependent reads.

Parameters:
- DEPTH, 4, MDU result FIFO entries (power of two, >=2).
- STARVE_LIMIT, 3, cycles a non-empty FIFO head may lose arbitration before WB is stalled.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst_n  input  1  synchronous active-low reset.
- wb_valid  input  1  pipeline writeback request this cycle.
- wb_rd  input  5  pipeline destination register.
- wb_data  input  32  pipeline result.
- wb_stall  output  1  pipeline must hold WB; WB request ignored this cycle.
- mc_issue_valid  input  1  MDU op issued this cycle.
- mc_issue_rd  input  5  destination of issued MDU op.
- mc_valid  input  1  MDU result offered.
- mc_ready  output  1  FIFO can accept; result transfers when mc_valid & mc_ready.
- mc_rd  input  5  MDU result destination.
- mc_data  input  32  MDU result.
- rs1  input  5  decode-stage source 1 query.
- rs2  input  5  decode-stage source 2 query.
- rs1_busy  output  1  busy[rs1], combinational.
- rs2_busy  output  1  busy[rs2], combinational.
- rf_we  output  1  to register-file WE3.
- rf_a3  output  5  to register-file A3.
- rf_wd  output  32  to register-file WD3.
- busy  output  32  scoreboard vector; bit 0 is always 0.
- err_waw  output  1  sticky flag: issue to a busy rd, or a WB write to a busy rd.

Behaviour:
- Reset (rst_n=0 at posedge):
  - FIFO empty; busy=0; starve counter=0; err_waw=0.
  - rf_we=0, rf_a3=0, rf_wd=0.
  - Reset mid-operation discards all buffered results and pending busy bits.
- Port-side timing:
  - rf_we, rf_a3 and rf_wd are registered: the winner selected in cycle N is presented from posedge N+1.
  - The register file commits it at the falling edge of cycle N+1.
- Arbitration (each cycle):
  - wb_stall = FIFO non-empty & starve_cnt >= STARVE_LIMIT.
  - If wb_stall=1: the FIFO head wins, wb_valid is ignored, starve_cnt resets to 0.
  - Else if wb_valid=1 & wb_rd!=0: WB wins. If the FIFO is non-empty, starve_cnt increments, saturating at STARVE_LIMIT.
  - Else if the FIFO is non-empty: the head wins and starve_cnt resets to 0.
  - A WB request with wb_rd=0 is dropped; its slot is free for the FIFO.
  - No winner -> rf_we=0; rf_a3 and rf_wd hold their previous values.
- FIFO:
  - mc_ready = !full.
  - Push when mc_valid & mc_ready & mc_rd!=0. An mc_rd=0 result is accepted and discarded.
  - Pop when the head wins arbitration.
  - Simultaneous push and pop while full is not allowed, since mc_ready=0.
  - Simultaneous push and pop at any other occupancy keeps the count unchanged.
  - Pointers wrap modulo DEPTH.
  - Ordering is strict FIFO.
- Scoreboard:
  - Set busy[mc_issue_rd] when mc_issue_valid & mc_issue_rd!=0.
  - Clear busy[rd] when a FIFO head with that rd wins arbitration.
  - Same register set and cleared in the same cycle: set wins.
  - WB writes never clear busy bits.
- err_waw:
  - Set on an issue to an already-busy rd.
  - Set on a WB win to a busy rd.
  - Cleared only by reset.
- Register x0: never written (rf_we stays 0 for rd=0); never marked busy.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles while wb_valid=1 -> rf_we=0, busy=0, mc_ready=1, err_waw=0.
- Plain WB: wb_valid=1, wb_rd=5, wb_data=0xDEADBEEF -> next cycle rf_we=1, rf_a3=5, rf_wd=0xDEADBEEF. With wb_rd=0 -> rf_we=0.
- MDU path:
  - Stimulus: issue rd=7, so busy[7]=1 and rs1=7 gives rs1_busy=1; then mc_valid with rd=7, data=42 and WB idle.
  - Response: rf_we=1, rf_a3=7, rf_wd=42 two cycles after the offer; busy[7]=0 in the same cycle rf_we rises.
- Starvation: FIFO holds rd=9, and wb_valid=1 with distinct rds every cycle -> WB wins 3 cycles, then wb_stall=1 for one cycle, rd=9 is written, and wb_stall falls.
- FIFO full/wrap:
  - Stimulus: push 4 MDU results with WB continuously busy.
  - Response: mc_ready=0 after the 4th push and a 5th offer is held.
  - Then drain and push 6 more -> written in exact offer order across the pointer wrap.
- Hazards:
  - Issue rd=3 twice -> err_waw=1 and stays 1.
  - Issue rd=4 in the same cycle its previous result drains -> busy[4] remains 1.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the 32x32 register file: merges in-order writeback with
// buffered multiply/divide results and tracks registers awaiting an MDU result.
module regfile_wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        wb_stall,
    input  logic        mc_issue_valid,
    input  logic [4:0]  mc_issue_rd,
    input  logic        mc_valid,
    output logic        mc_ready,
    input  logic [4:0]  mc_rd,
    input  logic [31:0] mc_data,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic        rf_we,
    output logic [4:0]  rf_a3,
    output logic [31:0] rf_wd,
    output logic [31:0] busy,
    output logic        err_waw
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);
    localparam logic [SW-1:0] STARVE_MX = SW'(STARVE_LIMIT);

    logic [4:0]    q_rd   [DEPTH];
    logic [31:0]   q_data [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [SW-1:0] starve_cnt;

    logic          fifo_empty, fifo_full, push, pop, wb_win, mc_win, issue_set;
    logic [4:0]    head_rd;
    logic [31:0]   head_data;
    logic [31:0]   busy_nxt;

    // MDU handshake: a result transfers on a cycle where mc_valid and mc_ready are
    // both high; mc_ready depends only on FIFO occupancy, never on mc_valid.
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);
    assign mc_ready   = !fifo_full;
    assign head_rd    = q_rd[rd_ptr];
    assign head_data  = q_data[rd_ptr];

    assign wb_stall  = !fifo_empty && (starve_cnt >= STARVE_MX);
    assign wb_win    = !wb_stall && wb_valid && (wb_rd != 5'd0);
    assign mc_win    = !fifo_empty && !wb_win;
    assign pop       = mc_win;
    assign push      = mc_valid && mc_ready && (mc_rd != 5'd0);
    assign issue_set = mc_issue_valid && (mc_issue_rd != 5'd0);

    assign rs1_busy = busy[rs1];
    assign rs2_busy = busy[rs2];

    // A new issue overrides the clear from a draining older result to the same rd.
    always_comb begin
        busy_nxt = busy;
        if (pop)       busy_nxt[head_rd]     = 1'b0;
        if (issue_set) busy_nxt[mc_issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[wr_ptr]   <= mc_rd;
            q_data[wr_ptr] <= mc_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            busy       <= '0;
            err_waw    <= 1'b0;
            rf_we      <= 1'b0;
            rf_a3      <= '0;
            rf_wd      <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (wb_stall || mc_win)
                starve_cnt <= '0;
            else if (wb_win && !fifo_empty && starve_cnt < STARVE_MX)
                starve_cnt <= starve_cnt + 1'b1;

            busy <= busy_nxt;

            if ((issue_set && busy[mc_issue_rd]) || (wb_win && busy[wb_rd]))
                err_waw <= 1'b1;

            if (wb_win) begin
                rf_we <= 1'b1;
                rf_a3 <= wb_rd;
                rf_wd <= wb_data;
            end else if (mc_win) begin
                rf_we <= 1'b1;
                rf_a3 <= head_rd;
                rf_wd <= head_data;
            end else begin
                rf_we <= 1'b0;
            end
        end
    end
endmodule
